// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types and constants for the multicycle control sequencer:
//   mc_state_t       - sequencer state code (legacy 4-bit constants)
//   trap_cause_t     - NONE / ILLEGAL / BUS_ERR
//   *_sel_t, alu_op_t - datapath select encodings
//   OP_*             - RV32I major opcodes
//   decode_target()  - state entered from DECODE for a given opcode
package ctrl_pkg;

  typedef logic [3:0] mc_state_t;

  localparam mc_state_t FETCH     = 4'd0;
  localparam mc_state_t DECODE    = 4'd1;
  localparam mc_state_t MEM_ADDR  = 4'd2;
  localparam mc_state_t EXEC_R    = 4'd3;
  localparam mc_state_t EXEC_I    = 4'd4;
  localparam mc_state_t EXEC_LUI  = 4'd5;
  localparam mc_state_t MEM_READ  = 4'd6;
  localparam mc_state_t MEM_WRITE = 4'd7;
  localparam mc_state_t MEM_WB    = 4'd8;
  localparam mc_state_t ALU_WB    = 4'd9;
  localparam mc_state_t BRANCH    = 4'd10;
  localparam mc_state_t JUMP      = 4'd11;
  localparam mc_state_t TRAP      = 4'd12;

  typedef enum logic [1:0] {NONE, ILLEGAL, BUS_ERR} trap_cause_t;

  typedef enum logic [0:0] {ADDR_PC, ADDR_RESULT} mem_addr_sel_t;
  typedef enum logic [0:0] {FETCH_INST, MEM_FUNCT_DEFINED} mem_funct3_sel_t;
  typedef enum logic [1:0] {RS1V, PC, PC_OLD} alu_src1_sel_t;
  typedef enum logic [1:0] {RS2V, IMM, PC_INC} alu_src2_sel_t;
  typedef enum logic [2:0] {ZERO, ALU_RESULT, ALU_CLOCKED, MEM_RD, TRAP_VEC} result_sel_t;
  typedef enum logic [1:0] {ADD_OP, SUB_OP, FUNCT_DEFINED, SRC2_OP} alu_op_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // AUIPC goes straight to write-back: PC_OLD+IMM is already computed
  // by the DECODE-cycle ALU pass and sits in the ALU output register.
  function automatic mc_state_t decode_target(input logic [6:0] op);
    case (op)
      OP_R:               return EXEC_R;
      OP_I:               return EXEC_I;
      OP_AUIPC:           return ALU_WB;
      OP_LUI:             return EXEC_LUI;
      OP_LOAD, OP_STORE:  return MEM_ADDR;
      OP_B:               return BRANCH;
      OP_JAL, OP_JALR:    return JUMP;
      default:            return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive non-ready cycles of a memory wait and flags expiry.
//   clk, reset (async, active-low)
//   clear     - zero the count (outside wait states or on mem_ready)
//   count_en  - a wait cycle without mem_ready
//   expired   - this non-ready cycle is the LIMIT-th in a row
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int TW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the sequencer leaves the wait state at the end of the
  // LIMIT-th non-ready cycle rather than one cycle later.
  assign expired = count_en && (count == TW'(LIMIT - 1));

endmodule

// File: rtl/mc_control.sv
// mc_control
// Multicycle RV32I control sequencer with a variable-latency memory handshake
// on fetch/load/store, illegal-opcode and bus-timeout traps, and a retire
// pulse per completed instruction. Outputs are decoded from the registered
// state (plus mem_ready in the wait states).
// Optional feature: define CTRL_MEM_TIMEOUT_EN to trap with BUS_ERR after
// MEM_TIMEOUT consecutive non-ready wait cycles; otherwise waits are unbounded.
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct3          - from the instruction register
//   mem_ready               - memory completes the current request
//   mem_req, mem_wren       - memory request / write
//   pc_update, inst_en, reg_wren, branch, branch_funct3
//   mem_addr_sel, mem_funct3_sel, alu_src1_sel, alu_src2_sel, result_sel, alu_op
//   trap, trap_cause, retire
module mc_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_wren,
  output logic            pc_update,
  output logic            inst_en,
  output logic            reg_wren,
  output logic            branch,
  output logic [2:0]      branch_funct3,
  output mem_addr_sel_t   mem_addr_sel,
  output mem_funct3_sel_t mem_funct3_sel,
  output alu_src1_sel_t   alu_src1_sel,
  output alu_src2_sel_t   alu_src2_sel,
  output result_sel_t     result_sel,
  output alu_op_t         alu_op,
  output logic            trap,
  output trap_cause_t     trap_cause,
  output logic            retire
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 1 || TW < 1) begin : g_bad_timeout
    $error("mc_control: MEM_TIMEOUT must be at least 1");
  end

  mc_state_t   state, state_next;
  trap_cause_t cause, cause_next;
  logic        in_wait;
  logic        timeout;

  assign in_wait = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);

`ifdef CTRL_MEM_TIMEOUT_EN
  // Held clear outside the wait states, so every wait starts from zero.
  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .TW    (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_wait || mem_ready),
    .count_en (in_wait && !mem_ready),
    .expired  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cause <= NONE;
    end else begin
      state <= state_next;
      cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
          cause_next = BUS_ERR;
        end
      end
      DECODE: begin
        state_next = decode_target(opcode);
        if (state_next == TRAP) cause_next = ILLEGAL;
      end
      MEM_ADDR:  state_next = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ, MEM_WRITE: begin
        if (mem_ready) begin
          state_next = (state == MEM_READ) ? MEM_WB : FETCH;
        end else if (timeout) begin
          state_next = TRAP;
          cause_next = BUS_ERR;
        end
      end
      EXEC_R, EXEC_I, EXEC_LUI, JUMP: state_next = ALU_WB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    mem_req        = 1'b0;
    mem_wren       = 1'b0;
    pc_update      = 1'b0;
    inst_en        = 1'b0;
    reg_wren       = 1'b0;
    branch         = 1'b0;
    branch_funct3  = 3'b000;
    mem_addr_sel   = ADDR_PC;
    mem_funct3_sel = FETCH_INST;
    alu_src1_sel   = RS1V;
    alu_src2_sel   = RS2V;
    result_sel     = ZERO;
    alu_op         = ADD_OP;
    trap           = 1'b0;
    trap_cause     = NONE;
    retire         = 1'b0;
    // While reset is held the state is already FETCH, but the request must
    // not reach the bus until reset is released.
    if (reset) begin
      case (state)
        FETCH: begin
          mem_req      = 1'b1;
          alu_src1_sel = PC;
          alu_src2_sel = PC_INC;
          result_sel   = ALU_RESULT;
          inst_en      = mem_ready;
          pc_update    = mem_ready;
        end
        DECODE: begin
          alu_src1_sel = (opcode == OP_JALR) ? RS1V : PC_OLD;
          alu_src2_sel = IMM;
        end
        MEM_ADDR: alu_src2_sel = IMM;
        MEM_READ, MEM_WRITE: begin
          mem_req        = 1'b1;
          mem_wren       = (state == MEM_WRITE);
          mem_addr_sel   = ADDR_RESULT;
          mem_funct3_sel = MEM_FUNCT_DEFINED;
          result_sel     = ALU_CLOCKED;
          retire         = (state == MEM_WRITE) && mem_ready;
        end
        EXEC_R: alu_op = FUNCT_DEFINED;
        EXEC_I: begin
          alu_src2_sel = IMM;
          alu_op       = FUNCT_DEFINED;
        end
        EXEC_LUI: begin
          alu_src2_sel = IMM;
          alu_op       = SRC2_OP;
        end
        JUMP: begin
          // Target came from the DECODE pass; this pass forms the link value.
          alu_src1_sel = PC_OLD;
          alu_src2_sel = PC_INC;
          result_sel   = ALU_CLOCKED;
          pc_update    = 1'b1;
        end
        MEM_WB: begin
          reg_wren   = 1'b1;
          result_sel = MEM_RD;
          retire     = 1'b1;
        end
        ALU_WB: begin
          reg_wren   = 1'b1;
          result_sel = ALU_CLOCKED;
          retire     = 1'b1;
        end
        BRANCH: begin
          alu_op        = SUB_OP;
          branch        = 1'b1;
          branch_funct3 = funct3;
          result_sel    = ALU_CLOCKED;
          retire        = 1'b1;
        end
        TRAP: begin
          trap       = 1'b1;
          trap_cause = cause;
          pc_update  = 1'b1;
          result_sel = TRAP_VEC;
        end
        default: ;
      endcase
    end
  end

endmodule
